// File: rtl/alu_issue_if.sv
// ============================================================================
// Module   : alu_issue_if
// Purpose  : Instruction handshake and ALU datapath bundle for alu_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic              instr_ld;
  logic [1:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [DATA_W-1:0] instr_imm;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              done;
  logic [DATA_W-1:0] done_result;
  logic              zero_flag;

  // Master is the environment: instruction source plus the combinational datapath.
  modport master (
    output instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, alu_result, alu_zero,
    input  instr_ready, alu_a, alu_b, alu_op, done, done_result, zero_flag
  );

  modport slave (
    input  instr_valid, instr_ld, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, alu_result, alu_zero,
    output instr_ready, alu_a, alu_b, alu_op, done, done_result, zero_flag
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue/writeback sequencer with a small register file around a
//            purely combinational 4-bit ALU datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
  parameter int DATA_W = 4,
  parameter int REG_N  = 4,
  parameter int ADDR_W = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  alu_issue_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [1:0]        alu_op_q;
  logic              done_q;
  logic [DATA_W-1:0] done_result_q;
  logic              zero_flag_q;

  // Ready must drop the instant reset asserts, so it is decoded rather than registered.
  assign bus.instr_ready = (state_q == IDLE) && !rst;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.done        = done_q;
  assign bus.done_result = done_result_q;
  assign bus.zero_flag   = zero_flag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      done_q        <= 1'b0;
      done_result_q <= '0;
      zero_flag_q   <= 1'b0;
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q  <= bus.instr_op;
            rd_q  <= bus.instr_rd;
            rs1_q <= bus.instr_rs1;
            rs2_q <= bus.instr_rs2;
            // Load result is known at accept; publish it on entry to WB.
            if (bus.instr_ld) begin
              done_q        <= 1'b1;
              done_result_q <= bus.instr_imm;
              zero_flag_q   <= (bus.instr_imm == '0);
              state_q       <= WB;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_a_q  <= regs_q[rs1_q];
          alu_b_q  <= regs_q[rs2_q];
          alu_op_q <= op_q;
          state_q  <= EXEC;
        end
        EXEC: begin
          done_q        <= 1'b1;
          done_result_q <= bus.alu_result;
          zero_flag_q   <= bus.alu_zero;
          state_q       <= WB;
        end
        WB: begin
          regs_q[rd_q] <= done_result_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Directed self-checking bench for alu_issue_ctrl with a behavioural
//            4-bit datapath. Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_issue_if #(.DATA_W(4), .ADDR_W(2)) bus ();

  alu_issue_ctrl #(.DATA_W(4), .REG_N(4), .ADDR_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath: add, sub, and, or; zero flag from the result.
  assign bus.alu_result = (bus.alu_op == 2'b00) ? bus.alu_a + bus.alu_b :
                          (bus.alu_op == 2'b01) ? bus.alu_a - bus.alu_b :
                          (bus.alu_op == 2'b10) ? (bus.alu_a & bus.alu_b) :
                                                  (bus.alu_a | bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 4'h0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Back-to-back field table: slots 0 and 4 are the ones accepted.
  logic       ld_t  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0] op_t  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
  logic [1:0] rd_t  [8] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3};
  logic [1:0] rs1_t [8] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [1:0] rs2_t [8] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
  logic [3:0] imm_t [8] = '{4'h0, 4'hF, 4'h9, 4'h6, 4'h0, 4'hC, 4'h7, 4'hA};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [1:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm);
    bus.instr_ld  = ld;
    bus.instr_op  = op;
    bus.instr_rd  = rd;
    bus.instr_rs1 = rs1;
    bus.instr_rs2 = rs2;
    bus.instr_imm = imm;
  endtask

  task automatic run_ld(input string tag, input logic [1:0] rd, input logic [3:0] imm);
    chk({tag, ".rdy_T"}, {7'd0, bus.instr_ready}, 8'd1);
    drive(1'b1, 2'd0, rd, 2'd0, 2'd0, imm);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    drive(1'b1, 2'd3, ~rd, 2'd0, 2'd0, ~imm);
    chk({tag, ".done"},   {7'd0, bus.done}, 8'd1);
    chk({tag, ".result"}, {4'd0, bus.done_result}, {4'd0, imm});
    chk({tag, ".zero"},   {7'd0, bus.zero_flag}, {7'd0, imm == 4'h0});
    chk({tag, ".rdy_wb"}, {7'd0, bus.instr_ready}, 8'd0);
    @(negedge clk);
    chk({tag, ".done_clr"}, {7'd0, bus.done}, 8'd0);
    chk({tag, ".rdy_idle"}, {7'd0, bus.instr_ready}, 8'd1);
  endtask

  task automatic run_alu(input string tag, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [3:0] exp_a, input logic [3:0] exp_b,
                         input logic [3:0] exp_r);
    chk({tag, ".rdy_T"}, {7'd0, bus.instr_ready}, 8'd1);
    drive(1'b0, op, rd, rs1, rs2, 4'h0);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    drive(1'b1, ~op, ~rd, ~rs1, ~rs2, 4'h5);
    chk({tag, ".rdy_issue"},  {7'd0, bus.instr_ready}, 8'd0);
    chk({tag, ".done_issue"}, {7'd0, bus.done}, 8'd0);
    @(negedge clk);
    chk({tag, ".alu_a"},  {4'd0, bus.alu_a}, {4'd0, exp_a});
    chk({tag, ".alu_b"},  {4'd0, bus.alu_b}, {4'd0, exp_b});
    chk({tag, ".alu_op"}, {6'd0, bus.alu_op}, {6'd0, op});
    chk({tag, ".done_exec"}, {7'd0, bus.done}, 8'd0);
    @(negedge clk);
    chk({tag, ".done"},   {7'd0, bus.done}, 8'd1);
    chk({tag, ".result"}, {4'd0, bus.done_result}, {4'd0, exp_r});
    chk({tag, ".zero"},   {7'd0, bus.zero_flag}, {7'd0, exp_r == 4'h0});
    chk({tag, ".a_hold"}, {4'd0, bus.alu_a}, {4'd0, exp_a});
    @(negedge clk);
    chk({tag, ".done_clr"}, {7'd0, bus.done}, 8'd0);
    chk({tag, ".rdy_idle"}, {7'd0, bus.instr_ready}, 8'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.instr_valid = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'h0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready",  {7'd0, bus.instr_ready}, 8'd0);
    chk("rst.done",   {7'd0, bus.done}, 8'd0);
    chk("rst.result", {4'd0, bus.done_result}, 8'd0);
    chk("rst.zero",   {7'd0, bus.zero_flag}, 8'd0);
    chk("rst.alu_a",  {4'd0, bus.alu_a}, 8'd0);
    chk("rst.alu_b",  {4'd0, bus.alu_b}, 8'd0);
    chk("rst.alu_op", {6'd0, bus.alu_op}, 8'd0);
    rst = 1'b0;
    #1;
    chk("rel.ready", {7'd0, bus.instr_ready}, 8'd1);

    // Loads, add, readback
    run_ld("ld_r1", 2'd1, 4'h5);
    run_ld("ld_r2", 2'd2, 4'h3);
    run_alu("add_r3", 2'b00, 2'd3, 2'd1, 2'd2, 4'h5, 4'h3, 4'h8);
    run_alu("rd_r3",  2'b11, 2'd3, 2'd3, 2'd3, 4'h8, 4'h8, 4'h8);

    // Subtract wrap and zero
    run_alu("sub_wrap", 2'b01, 2'd0, 2'd2, 2'd1, 4'h3, 4'h5, 4'hE);
    run_alu("sub_zero", 2'b01, 2'd1, 2'd1, 2'd1, 4'h5, 4'h5, 4'h0);
    run_alu("rd_r1",    2'b11, 2'd1, 2'd1, 2'd1, 4'h0, 4'h0, 4'h0);

    // Logic ops with aliasing
    run_ld("ld_r1b", 2'd1, 4'h5);
    run_alu("and_alias", 2'b10, 2'd1, 2'd1, 2'd2, 4'h5, 4'h3, 4'h1);
    run_alu("or_alias",  2'b11, 2'd2, 2'd1, 2'd2, 4'h1, 4'h3, 4'h3);

    // Back-to-back with valid held high: r0=E r1=1 r2=3 r3=8
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b.rdy%0d", k),  {7'd0, bus.instr_ready}, {7'd0, (k % 4) == 0});
      chk($sformatf("b2b.done%0d", k), {7'd0, bus.done}, {7'd0, (k % 4) == 3});
      if (k == 2) chk("b2b.a0", {4'd0, bus.alu_a}, 8'h01);
      if (k == 3) chk("b2b.res0", {4'd0, bus.done_result}, 8'h04);
      if (k == 6) chk("b2b.a1", {4'd0, bus.alu_a}, 8'h04);
      if (k == 7) chk("b2b.res1", {4'd0, bus.done_result}, 8'h03);
      drive(ld_t[k], op_t[k], rd_t[k], rs1_t[k], rs2_t[k], imm_t[k]);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    run_alu("b2b.rd_r3", 2'b11, 2'd3, 2'd3, 2'd3, 4'h8, 4'h8, 4'h8);
    run_alu("b2b.rd_r0", 2'b11, 2'd0, 2'd0, 2'd0, 4'h3, 4'h3, 4'h3);

    // Abort during EXEC of ADD r3=r1+r2 (r1=1, r2=3)
    drive(1'b0, 2'b00, 2'd3, 2'd1, 2'd2, 4'h0);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("abort.a_exec", {4'd0, bus.alu_a}, 8'h01);
    rst = 1'b1;
    #1;
    chk("abort.done",   {7'd0, bus.done}, 8'd0);
    chk("abort.ready",  {7'd0, bus.instr_ready}, 8'd0);
    chk("abort.alu_a",  {4'd0, bus.alu_a}, 8'd0);
    chk("abort.alu_b",  {4'd0, bus.alu_b}, 8'd0);
    chk("abort.result", {4'd0, bus.done_result}, 8'd0);
    chk("abort.zero",   {7'd0, bus.zero_flag}, 8'd0);
    @(negedge clk);
    chk("abort.done2", {7'd0, bus.done}, 8'd0);
    rst = 1'b0;
    #1;
    chk("abort.rel_ready", {7'd0, bus.instr_ready}, 8'd1);
    chk("abort.rel_done",  {7'd0, bus.done}, 8'd0);
    run_alu("abort.rd_r3", 2'b11, 2'd3, 2'd3, 2'd3, 4'h0, 4'h0, 4'h0);
    run_alu("abort.add",   2'b00, 2'd0, 2'd1, 2'd2, 4'h0, 4'h0, 4'h0);
    run_ld("abort.ld", 2'd2, 4'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
